sng_bitstream_gen: RTL and testbench

//  Stochastic number generator (SNG). Sits directly downstream of counter_n_bit.

---
 rtl/sc_pkg.sv | 15 +
 rtl/sng_compare.sv | 14 +
 rtl/sng_bitstream_gen.sv | 92 +++++++++
 tb/tb_sng_bitstream_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Types and helpers shared by the stochastic-computing blocks.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_t;

    // Width of a counter that has to hold the values 0..len inclusive.
    function automatic int SC_LEN_W(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sng_compare.sv
// N-bit unsigned less-than, used as the SNG comparator: lt = (a < b).
// Latency: combinational. Backpressure: none, no state.
// Flow: pure function of a and b; shared by all SNG variants.
module sng_compare #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = (a < b);

endmodule

// File: rtl/sng_bitstream_gen.sv
// Stochastic number generator: one operand in, LEN-bit unipolar stream out (bit = rand_in < value).
// Latency: accept -> first bit_valid 1 cycle; final handshake -> done 1 cycle. Build option SNG_BIPOLAR_EN.
// Backpressure: bit_ready=0 freezes len_cnt and the external counter, so bit_out stays stable.
module sng_bitstream_gen
    import sc_pkg::*;
#(
    parameter int N   = 10,
    parameter int LEN = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_value,
    output logic         in_ready,
    input  logic         abort,
    input  logic [N-1:0] rand_in,
    output logic         cnt_enable,
    output logic         cnt_restart,
    output logic         bit_out,
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         busy,
    output logic         done
);

    localparam int            LW   = SC_LEN_W(LEN);
    localparam logic [LW-1:0] LAST = LW'(LEN - 1);
    localparam logic [N-1:0]  MSB  = {1'b1, {(N-1){1'b0}}};

    sng_state_t    state;
    logic [N-1:0]  value_reg;
    logic [LW-1:0] len_cnt;
    logic [N-1:0]  load_val;
    logic          cmp_lt;

`ifdef SNG_BIPOLAR_EN
    // Offset binary: flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
    assign load_val = in_value ^ MSB;
`else
    assign load_val = in_value;
    logic unused_msb;
    assign unused_msb = ^MSB;
`endif

    sng_compare #(.N(N)) u_cmp (
        .a  (rand_in),
        .b  (value_reg),
        .lt (cmp_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            value_reg <= '0;
            len_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value_reg <= load_val;
                        len_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // abort takes priority over a final handshake in the same cycle
                    if (abort) begin
                        state <= IDLE;
                    end else if (bit_ready) begin
                        len_cnt <= len_cnt + LW'(1);
                        if (len_cnt == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready    = !rst && (state == IDLE);
    assign bit_valid   = !rst && (state == RUN);
    assign bit_out     = cmp_lt;
    assign cnt_enable  = bit_valid && bit_ready;
    // Restarting on accept makes the counter read index 0 in the first RUN cycle.
    assign cnt_restart = !rst && (((state == IDLE) && in_valid) ||
                                  ((state != IDLE) && abort));
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_sng_bitstream_gen.sv
// Bench for sng_bitstream_gen (N=4, LEN=16) with an ideal bit-reversed 4-bit counter as random source.
module tb_sng_bitstream_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_value = '0;
    logic       in_ready;
    logic       abort = 1'b0;
    logic [3:0] rand_in;
    logic       cnt_enable;
    logic       cnt_restart;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready = 1'b0;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [3:0] idx = '0;
    bit         exp_q[$];
    int         mon_ones = 0;
    int         mon_hs   = 0;

    typedef struct {
        logic [3:0] value;
        bit         rnd;
        int         ones;
    } vec_t;

    vec_t vecs[6];

    sng_bitstream_gen #(.N(4), .LEN(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_value    (in_value),
        .in_ready    (in_ready),
        .abort       (abort),
        .rand_in     (rand_in),
        .cnt_enable  (cnt_enable),
        .cnt_restart (cnt_restart),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Ideal counter_n_bit (BOUND=15): index wraps 15->0, output is the bit-reversed index.
    always @(posedge clk) begin
        if (rst || cnt_restart) idx <= '0;
        else if (cnt_enable)    idx <= idx + 4'd1;
    end
    assign rand_in = {idx[0], idx[1], idx[2], idx[3]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_load(input logic [3:0] v);
`ifdef SNG_BIPOLAR_EN
        return v ^ 4'b1000;
`else
        return v;
`endif
    endfunction

    function automatic logic [3:0] rev4(input int k);
        logic [3:0] x;
        x = 4'(k);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Scoreboard side: compare the offered bit with the queue head, pop on handshake.
    always @(negedge clk) begin
        if (!rst && bit_valid) begin
            if (exp_q.size() == 0) begin
                check("bit_unexpected", 1, 0);
            end else begin
                check("bit_out", bit_out, exp_q[0]);
                check("cnt_enable", cnt_enable, bit_ready);
                if (bit_ready) begin
                    void'(exp_q.pop_front());
                    if (bit_out) mon_ones++;
                    mon_hs++;
                end
            end
        end
    end

    task automatic load(input logic [3:0] v);
        int n;
        logic [3:0] eff;
        eff = model_load(v);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(rev4(k) < eff);
        mon_ones = 0;
        mon_hs   = 0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_value = v;
        in_valid = 1'b1;
        #2;
        check("accept_restart", cnt_restart, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_valid", bit_valid, 1);
    endtask

    task automatic run_stream(input logic [3:0] v, input bit rnd, input int exp_ones);
        int hs, cyc;
        bit fire, early;
        load(v);
        hs = 0; cyc = 0; early = 0;
        while (hs < 16 && cyc < 300) begin
            bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            fire = bit_valid && bit_ready;
            if (done) early = 1;
            @(posedge clk); #1;
            if (fire) hs++;
            cyc++;
        end
        bit_ready = 1'b0;
        check("handshakes", hs, 16);
        check("early_done", early, 0);
        check("done_pulse", done, 1);
        check("ones_count", mon_ones, exp_ones);
        @(posedge clk); #1;
        check("done_width", done, 0);
        check("ready_after", in_ready, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
`ifdef SNG_BIPOLAR_EN
        vecs[0] = '{4'd8,  1'b0, 0};
        vecs[1] = '{4'd0,  1'b0, 8};
        vecs[2] = '{4'd7,  1'b0, 15};
        vecs[3] = '{4'd9,  1'b1, 1};
        vecs[4] = '{4'd12, 1'b0, 4};
        vecs[5] = '{4'd3,  1'b1, 11};
`else
        vecs[0] = '{4'd5,  1'b0, 5};
        vecs[1] = '{4'd0,  1'b0, 0};
        vecs[2] = '{4'd15, 1'b0, 15};
        vecs[3] = '{4'd9,  1'b1, 9};
        vecs[4] = '{4'd12, 1'b0, 12};
        vecs[5] = '{4'd1,  1'b1, 1};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        #2;
        check("post_rst_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) run_stream(vecs[i].value, vecs[i].rnd, vecs[i].ones);

        // Abort after 6 handshakes, then a fresh stream must restart at index 0
        load(4'd7);
        bit_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bit_ready = 1'b0;
        abort = 1'b1;
        #2;
        check("abort_restart", cnt_restart, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_hs", mon_hs, 6);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 1);
        exp_q.delete();
        run_stream(4'd3, 1'b0, int'(model_load(4'd3)));

        // Synchronous reset in the middle of a stream
        load(4'd9);
        bit_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_valid", bit_valid, 0);
        check("midrst_cnt_en", cnt_enable, 0);
        check("midrst_restart", cnt_restart, 0);
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready_held", in_ready, 0);
        bit_ready = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        #2;
        check("midrst_ready_after", in_ready, 1);
        check("midrst_idx", idx, 0);
        run_stream(4'd5, 1'b1, int'(model_load(4'd5)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
